// File: rtl/cache_controller_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cache_controller_pkg : shared widths, base address and FSM encoding       |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
package cache_controller_pkg;

  localparam int          TAG_W     = 11;
  localparam int          INDEX_W   = 6;
  localparam int          WORD_W    = 32;
  localparam logic [31:0] DATA_BASE = 32'd1024;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/cache_way.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cache_way : one way of valid/tag/data storage with hit compare            |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module cache_way
  import cache_controller_pkg::*;
#(
  parameter int SETS = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] index,
  input  logic [TAG_W-1:0]   tag,
  input  logic               fill,
  input  logic               update,
  input  logic [WORD_W-1:0]  wdata,
  output logic               hit,
  output logic [WORD_W-1:0]  data
);

  logic [SETS-1:0]   valid;
  logic [TAG_W-1:0]  tags  [SETS];
  logic [WORD_W-1:0] words [SETS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= '0;
    end else if (fill) begin
      valid[index] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset; valid alone qualifies them.
  always_ff @(posedge clk) begin
    if (fill) begin
      tags[index] <= tag;
    end
    if (fill || update) begin
      words[index] <= wdata;
    end
  end

  assign hit  = valid[index] && (tags[index] == tag);
  assign data = words[index];

endmodule
`default_nettype wire

// File: rtl/cache_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cache_controller : 2-way set-associative, write-through no-allocate cache |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module cache_controller #(
  parameter logic [31:0] DATA_BASE = cache_controller_pkg::DATA_BASE,
  parameter int          SETS      = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic [31:0] sram_address,
  output logic [31:0] sram_wdata,
  output logic        sram_read,
  output logic        sram_write,
  input  logic [31:0] sram_rdata,
  input  logic        sram_ready
);

  import cache_controller_pkg::*;

  state_t              state;
  state_t              next_state;
  logic [SETS-1:0]     lru;

  logic [31:0]         offset_addr;
  logic [INDEX_W-1:0]  index;
  logic [TAG_W-1:0]    tag;
  logic                unused_addr_bits;

  logic                hit0, hit1, hit;
  logic [WORD_W-1:0]   data0, data1;
  logic                fill0, fill1, upd0, upd1;
  logic [WORD_W-1:0]   way_wdata;
  logic                lru_set, lru_val;
  logic                rd_req, wr_req;

  assign offset_addr      = address - DATA_BASE;
  assign index            = offset_addr[7:2];
  assign tag              = offset_addr[18:8];
  assign unused_addr_bits = ^{offset_addr[31:19], offset_addr[1:0]};

  assign hit = hit0 | hit1;

  cache_way #(.SETS(SETS)) u_way0 (
    .clk    (clk),
    .rst    (rst),
    .index  (index),
    .tag    (tag),
    .fill   (fill0),
    .update (upd0),
    .wdata  (way_wdata),
    .hit    (hit0),
    .data   (data0)
  );

  cache_way #(.SETS(SETS)) u_way1 (
    .clk    (clk),
    .rst    (rst),
    .index  (index),
    .tag    (tag),
    .fill   (fill1),
    .update (upd1),
    .wdata  (way_wdata),
    .hit    (hit1),
    .data   (data1)
  );

  always_comb begin
    next_state = state;
    rdata      = hit1 ? data1 : data0;
    ready      = 1'b1;
    rd_req     = 1'b0;
    wr_req     = 1'b0;
    fill0      = 1'b0;
    fill1      = 1'b0;
    upd0       = 1'b0;
    upd1       = 1'b0;
    way_wdata  = wdata;
    lru_set    = 1'b0;
    lru_val    = 1'b0;
    case (state)
      S_IDLE: begin
        if (MEM_W_EN) begin
          wr_req     = 1'b1;
          ready      = 1'b0;
          upd0       = hit0;
          upd1       = hit1;
          lru_set    = hit;
          lru_val    = hit1;
          next_state = S_WRITE;
        end else if (MEM_R_EN) begin
          if (hit) begin
            lru_set = 1'b1;
            lru_val = hit1;
          end else begin
            rd_req     = 1'b1;
            ready      = 1'b0;
            next_state = S_READ;
          end
        end
      end
      S_READ: begin
        rd_req    = 1'b1;
        rdata     = sram_rdata;
        ready     = sram_ready;
        way_wdata = sram_rdata;
        if (sram_ready) begin
          // The LRU bit names the last-used way, so the victim is the other one.
          fill0      = lru[index];
          fill1      = ~lru[index];
          lru_set    = 1'b1;
          lru_val    = ~lru[index];
          next_state = S_IDLE;
        end
      end
      S_WRITE: begin
        wr_req = 1'b1;
        ready  = sram_ready;
        if (sram_ready) begin
          next_state = S_IDLE;
        end
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      lru   <= '0;
    end else begin
      state <= next_state;
      if (lru_set) begin
        lru[index] <= lru_val;
      end
    end
  end

  // Gated by reset so the SRAM strobes drop the instant reset asserts.
  assign sram_read    = rst & rd_req;
  assign sram_write   = rst & wr_req;
  assign sram_address = address;
  assign sram_wdata   = wdata;

endmodule
`default_nettype wire

// File: tb/tb_cache_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_cache_controller : scoreboard bench with a 3-cycle SRAM model          |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_cache_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        MEM_R_EN = 1'b0;
  logic        MEM_W_EN = 1'b0;
  logic [31:0] address = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic        ready;
  logic [31:0] sram_address;
  logic [31:0] sram_wdata;
  logic        sram_read;
  logic        sram_write;
  logic [31:0] sram_rdata;
  logic        sram_ready;

  always #5 clk = ~clk;

  cache_controller dut (
    .clk          (clk),
    .rst          (rst),
    .MEM_R_EN     (MEM_R_EN),
    .MEM_W_EN     (MEM_W_EN),
    .address      (address),
    .wdata        (wdata),
    .rdata        (rdata),
    .ready        (ready),
    .sram_address (sram_address),
    .sram_wdata   (sram_wdata),
    .sram_read    (sram_read),
    .sram_write   (sram_write),
    .sram_rdata   (sram_rdata),
    .sram_ready   (sram_ready)
  );

  // SRAM model: completes on the 4th consecutive cycle of a strobe.
  logic [31:0] mem [0:4095];
  logic [1:0]  sram_cnt;
  logic        pre_en = 1'b0;
  logic [31:0] pre_addr = 32'h0;
  logic [31:0] pre_data = 32'h0;

  function automatic logic [11:0] midx(input logic [31:0] a);
    return {a[17:16], a[11:2]};
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sram_cnt <= 2'd0;
    else if ((sram_read || sram_write) && !sram_ready) sram_cnt <= sram_cnt + 2'd1;
    else sram_cnt <= 2'd0;
  end

  assign sram_ready = (sram_read || sram_write) && (sram_cnt == 2'd3);
  assign sram_rdata = mem[midx(sram_address)];

  always_ff @(posedge clk) begin
    if (pre_en) mem[midx(pre_addr)] <= pre_data;
    else if (sram_write && sram_ready) mem[midx(sram_address)] <= sram_wdata;
  end

  // Scoreboard
  typedef struct {
    int          id;
    bit          is_write;
    logic [31:0] data;
    int          cycles;
    int          rd_cycles;
    int          wr_cycles;
  } exp_t;

  exp_t sb[$];
  int   total  = 0;
  int   passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Monitor: counts cycles of the outstanding request and scores it on ready.
  int   mcyc = 0;
  int   mrd  = 0;
  int   mwr  = 0;
  exp_t me;

  always @(negedge clk) begin
    if (rst && (MEM_R_EN || MEM_W_EN)) begin
      mcyc++;
      mrd += int'(sram_read);
      mwr += int'(sram_write);
      if (ready) begin
        if (sb.size() == 0) begin
          check("unexpected_ready", 32'(sb.size()), 32'd1);
        end else begin
          me = sb.pop_front();
          if (!me.is_write) check($sformatf("txn%0d_rdata", me.id), rdata, me.data);
          check($sformatf("txn%0d_cycles", me.id), 32'(mcyc), 32'(me.cycles));
          check($sformatf("txn%0d_sram_read_cycles", me.id), 32'(mrd), 32'(me.rd_cycles));
          check($sformatf("txn%0d_sram_write_cycles", me.id), 32'(mwr), 32'(me.wr_cycles));
        end
        mcyc = 0;
        mrd  = 0;
        mwr  = 0;
      end
    end else begin
      mcyc = 0;
      mrd  = 0;
      mwr  = 0;
    end
  end

  task automatic do_req(input int id, input bit wr, input bit rd, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] exp_data,
                        input int cyc, input int rdc, input int wrc);
    exp_t e;
    bit   done;
    int   n;
    e.id = id; e.is_write = wr; e.data = exp_data;
    e.cycles = cyc; e.rd_cycles = rdc; e.wr_cycles = wrc;
    sb.push_back(e);
    @(posedge clk); #1;
    MEM_W_EN = wr;
    MEM_R_EN = rd;
    address  = addr;
    wdata    = wd;
    done = 1'b0;
    n    = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
      if (ready) done = 1'b1;
    end
    if (!done) begin
      total++;
      $display("FAIL txn%0d_timeout: got no ready after %0d cycles, required ready", id, n);
    end
    @(posedge clk); #1;
    MEM_W_EN = 1'b0;
    MEM_R_EN = 1'b0;
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    pre_addr = a;
    pre_data = d;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1);
  end

  initial begin
    pre_en = 1'b1;
    @(posedge clk); #1;
    preload(32'h0000_0400, 32'hDEAD_BEEF);
    preload(32'h0001_0400, 32'h1111_0000);
    preload(32'h0002_0400, 32'h2222_0000);
    preload(32'h0000_0800, 32'h0800_0800);
    pre_en = 1'b0;
    check("rst_sram_read", {31'b0, sram_read}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("idle_ready", {31'b0, ready}, 32'd1);
    check("idle_sram_read", {31'b0, sram_read}, 32'd0);
    check("idle_sram_write", {31'b0, sram_write}, 32'd0);

    // Cold miss, then hit
    do_req(1,  0, 1, 32'h0000_0400, 32'h0, 32'hDEAD_BEEF, 4, 4, 0);
    do_req(2,  0, 1, 32'h0000_0400, 32'h0, 32'hDEAD_BEEF, 1, 0, 0);
    // Fill second way of set 0, then evict the LRU line
    do_req(3,  0, 1, 32'h0001_0400, 32'h0, 32'h1111_0000, 4, 4, 0);
    do_req(4,  0, 1, 32'h0002_0400, 32'h0, 32'h2222_0000, 4, 4, 0);
    do_req(5,  0, 1, 32'h0001_0400, 32'h0, 32'h1111_0000, 1, 0, 0);
    do_req(6,  0, 1, 32'h0000_0400, 32'h0, 32'hDEAD_BEEF, 4, 4, 0);
    // Write hit updates the cached word
    do_req(7,  1, 0, 32'h0000_0400, 32'h1234_5678, 32'h0, 4, 0, 4);
    do_req(8,  0, 1, 32'h0000_0400, 32'h0, 32'h1234_5678, 1, 0, 0);
    // Write miss goes to SRAM only
    do_req(9,  1, 0, 32'h0000_0800, 32'hA5A5_0800, 32'h0, 4, 0, 4);
    do_req(10, 0, 1, 32'h0000_0800, 32'h0, 32'hA5A5_0800, 4, 4, 0);
    do_req(11, 0, 1, 32'h0000_0400, 32'h0, 32'h1234_5678, 1, 0, 0);

    // Reset in the middle of a read miss
    @(posedge clk); #1;
    MEM_R_EN = 1'b1;
    address  = 32'h0002_0400;
    @(posedge clk);
    @(posedge clk); #2;
    check("pre_rst_sram_read", {31'b0, sram_read}, 32'd1);
    rst      = 1'b0;
    MEM_R_EN = 1'b0;
    #1;
    check("mid_rst_sram_read", {31'b0, sram_read}, 32'd0);
    check("mid_rst_sram_write", {31'b0, sram_write}, 32'd0);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_ready", {31'b0, ready}, 32'd1);
    check("post_rst_sram_read", {31'b0, sram_read}, 32'd0);
    do_req(12, 0, 1, 32'h0000_0400, 32'h0, 32'h1234_5678, 4, 4, 0);

    // Simultaneous read and write: the write wins
    do_req(13, 1, 1, 32'h0000_0400, 32'h55AA_55AA, 32'h0, 4, 0, 4);
    do_req(14, 0, 1, 32'h0000_0400, 32'h0, 32'h55AA_55AA, 1, 0, 0);

    repeat (3) @(posedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
